bench_capture_sequencer: RTL and testbench
==========================================

// Module: bench_capture_sequencer
// PURPOSE
//  Sequences one benchmark DUT through a capture run: holds the DUT in reset, releases it, and waits a settle window.
//  Then drives a stimulus index N each cycle, samples the DUT's single-bit output, and hands the packed record to the logger.
//  The record goes out over a valid/ready handshake.
//  Sits between the bench top and the DUT, replacing ad-hoc timed initial blocks.
// PARAMETERS
//  RST_CYCLES     2   cycles dut_rst held high after start (>=1)
//  SETTLE_CYCLES  1   cycles after dut_rst release before first sample (>=0)
//  NUM_SAMPLES    8   output bits captured per run (1..64)
//  N_W            3   width of stimulus index N
// PORTS
//  CK         in   1            single clock, all logic on posedge
//  reset      in   1            synchronous, active-high
//  start      in   1            one-cycle pulse; begins run from IDLE or DONE
//  dut_rst    out  1            reset to DUT, active-high
//  stim_n     out  N_W          stimulus index presented to DUT
//  dut_out    in   1            DUT single-bit output (output_single)
//  rec_valid  out  1            capture record valid
//  rec_ready  in   1            logger accepts record
//  rec_n0     out  N_W          stim_n value at first sample
//  rec_bits   out  NUM_SAMPLES  captured bits, bit i = sample i
//  busy       out  1            high in RESET_DUT..EMIT
//  done       out  1            high in DONE
// BEHAVIOUR
//  Reset values: state=IDLE, dut_rst=1, stim_n=0, rec_valid=0, rec_n0=0, rec_bits=0, busy=0, done=0.
//  Reset is sampled every cycle. Asserting it mid-run aborts immediately to IDLE; any pending record is dropped.
//  States:
//   IDLE:      dut_rst=1. start -> RESET_DUT, load cnt=RST_CYCLES-1, stim_n=0.
//   RESET_DUT: dut_rst=1; cnt==0 -> SETTLE (cnt=SETTLE_CYCLES-1), or SAMPLE if SETTLE_CYCLES==0.
//   SETTLE:    dut_rst=0; cnt==0 -> SAMPLE, cnt=NUM_SAMPLES-1.
//   SAMPLE:    dut_rst=0.
//              Each cycle, rec_bits[NUM_SAMPLES-1-cnt] <= dut_out and stim_n <= stim_n+1.
//              stim_n wraps mod 2**N_W.
//              rec_n0 is latched on the first SAMPLE cycle.
//              cnt==0 -> EMIT.
//   EMIT:      rec_valid=1; rec_n0/rec_bits stable while valid && !ready.
//              valid && ready -> DONE; rec_valid drops the next cycle.
//   DONE:      done=1, dut_rst=0, stim_n holds. start -> RESET_DUT (full restart).
//  Timing: start accepted at edge t0.
//   dut_rst is high for exactly RST_CYCLES cycles after t0.
//   The first sample is taken at edge t0+RST_CYCLES+SETTLE_CYCLES+1.
//   rec_valid rises the cycle after the last sample.
//  dut_out is sampled at the same edge that advances stim_n. The bit therefore reflects the DUT's response to the prior stim_n.
//  start outside IDLE/DONE is ignored, including start during EMIT.
//  rec_ready while rec_valid=0 is ignored.
//  Counter width: $clog2 of max(RST_CYCLES, SETTLE_CYCLES, NUM_SAMPLES), minimum 1.
// STRUCTURE
//  Package bench_seq_pkg:
//   - state_e enum {IDLE, RESET_DUT, SETTLE, SAMPLE, EMIT, DONE}
//   - capture_rec_t struct {n0, bits}
//  One sub-module: seq_down_counter. Parameterised width, with load/enable/zero-flag. Shared by the three timed states.
//  FSM and capture register live in this module.
// TESTING
//  1 Defaults; start at cyc 5, dut_out tied 1.
//    -> dut_rst high cyc 6-7, first sample cyc 9, rec_bits=8'hFF, rec_n0=0, rec_valid cyc 17.
//  2 dut_out = stim_n[0], rec_ready held 1.
//    -> rec_bits=8'hAA (sample i holds prior stim parity); rec_valid high exactly 1 cycle; done next cycle.
//  3 rec_ready low 4 cycles after rec_valid.
//    -> rec_valid and rec_bits held unchanged all 4 cycles; DONE on the first ready cycle.
//  4 NUM_SAMPLES=10, N_W=3.
//    -> stim_n sequence 0..7,0,1 (wrap); last stim_n=2 in DONE.
//  5 reset asserted during SAMPLE (3rd sample).
//    -> next cycle IDLE, dut_rst=1, rec_valid=0, rec_bits=0; a later start runs a clean full sequence.
//  6 start pulsed during SETTLE and EMIT -> ignored.
//    start in DONE -> dut_rst rises next cycle, done=0.
//    SETTLE_CYCLES=0 -> first sample at t0+RST_CYCLES+1.

Source files
------------

// File: rtl/bench_seq_pkg.sv
// Shared types for the capture sequencer: FSM states, the capture record, counter sizing.
package bench_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RESET_DUT,
        SETTLE,
        SAMPLE,
        EMIT,
        DONE
    } state_e;

    localparam int REC_N_W_MAX  = 16;
    localparam int REC_BITS_MAX = 64;

    // Sized for the widest supported run; instances use the low N_W / NUM_SAMPLES bits.
    typedef struct packed {
        logic [REC_N_W_MAX-1:0]  n0;
        logic [REC_BITS_MAX-1:0] bits;
    } capture_rec_t;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down counter with zero flag; holds at zero. Load takes priority over enable.
// Result visible one cycle after load/enable; no backpressure.
module seq_down_counter #(
    parameter int W = 3
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/bench_capture_sequencer.sv
// Drives one DUT through reset, settle and NUM_SAMPLES capture cycles, then offers the record.
// Record held stable on rec_valid until rec_ready; reset aborts and drops any pending record.
module bench_capture_sequencer
    import bench_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 1,
    parameter int NUM_SAMPLES   = 8,
    parameter int N_W           = 3
) (
    input  logic                   CK,
    input  logic                   reset,
    input  logic                   start,
    output logic                   dut_rst,
    output logic [N_W-1:0]         stim_n,
    input  logic                   dut_out,
    output logic                   rec_valid,
    input  logic                   rec_ready,
    output logic [N_W-1:0]         rec_n0,
    output logic [NUM_SAMPLES-1:0] rec_bits,
    output logic                   busy,
    output logic                   done
);

    localparam int CW = cnt_width(RST_CYCLES, SETTLE_CYCLES, NUM_SAMPLES);
    localparam logic [CW-1:0] L_RST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] L_SET = (SETTLE_CYCLES > 0) ? CW'(SETTLE_CYCLES - 1) : '0;
    localparam logic [CW-1:0] L_SMP = CW'(NUM_SAMPLES - 1);

    state_e          r_state;
    state_e          w_next;
    logic            w_load;
    logic            w_en;
    logic [CW-1:0]   w_load_val;
    logic [CW-1:0]   w_cnt;
    logic            w_zero;
    logic [N_W-1:0]  r_stim_n;
    capture_rec_t    r_rec;
    logic            w_first;
    logic [5:0]      w_bit_idx;
    logic            w_unused_rec;

    seq_down_counter #(.W(CW)) u_cnt (
        .i_clk      (CK),
        .i_reset    (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_en       (w_en),
        .o_cnt      (w_cnt),
        .o_zero     (w_zero)
    );

    always_ff @(posedge CK) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = L_RST;
        w_en       = 1'b0;
        dut_rst    = 1'b0;
        rec_valid  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (r_state)
            IDLE: begin
                dut_rst = 1'b1;
                busy    = 1'b0;
                if (start) begin
                    w_next = RESET_DUT;
                    w_load = 1'b1;
                end
            end
            RESET_DUT: begin
                dut_rst = 1'b1;
                if (w_zero) begin
                    w_load = 1'b1;
                    if (SETTLE_CYCLES == 0) begin
                        w_next     = SAMPLE;
                        w_load_val = L_SMP;
                    end else begin
                        w_next     = SETTLE;
                        w_load_val = L_SET;
                    end
                end else begin
                    w_en = 1'b1;
                end
            end
            SETTLE: begin
                if (w_zero) begin
                    w_next     = SAMPLE;
                    w_load     = 1'b1;
                    w_load_val = L_SMP;
                end else begin
                    w_en = 1'b1;
                end
            end
            SAMPLE: begin
                if (w_zero) w_next = EMIT;
                else        w_en   = 1'b1;
            end
            EMIT: begin
                rec_valid = 1'b1;
                if (rec_ready) w_next = DONE;
            end
            DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (start) begin
                    w_next = RESET_DUT;
                    w_load = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Sample i lands in bit i: counter runs NUM_SAMPLES-1 down to 0 across the window.
    assign w_first   = (w_cnt == L_SMP);
    assign w_bit_idx = 6'(L_SMP - w_cnt);

    always_ff @(posedge CK) begin
        if (reset) begin
            r_stim_n <= '0;
            r_rec    <= '0;
        end else if (((r_state == IDLE) || (r_state == DONE)) && start) begin
            r_stim_n <= '0;
            r_rec    <= '0;
        end else if (r_state == SAMPLE) begin
            r_stim_n                <= r_stim_n + N_W'(1);
            r_rec.bits[w_bit_idx]   <= dut_out;
            if (w_first) r_rec.n0   <= REC_N_W_MAX'(r_stim_n);
        end
    end

    // Record bits above the configured widths stay zero and are deliberately left unconnected.
    assign w_unused_rec = ^r_rec;

    assign stim_n   = r_stim_n;
    assign rec_n0   = r_rec.n0[N_W-1:0];
    assign rec_bits = r_rec.bits[NUM_SAMPLES-1:0];

endmodule

// File: tb/tb_bench_capture_sequencer.sv
// Directed bench for the capture sequencer: three configurations, scoreboarded records plus timing checks.
module tb_bench_capture_sequencer;

    logic CK = 1'b0;
    always #5 CK = ~CK;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [63:0] n0;
        logic [63:0] bits;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    exp_t e_a, e_b, e_c;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Instance A: default parameters
    logic       reset_a, start_a, dut_rst_a, dut_out_a, rec_valid_a, rec_ready_a, busy_a, done_a;
    logic [2:0] stim_a, rec_n0_a;
    logic [7:0] rec_bits_a;
    int         mode_a;

    assign dut_out_a = (mode_a == 0) ? 1'b1 : (mode_a == 1) ? stim_a[0] : ~stim_a[0];

    bench_capture_sequencer u_a (
        .CK(CK), .reset(reset_a), .start(start_a), .dut_rst(dut_rst_a), .stim_n(stim_a),
        .dut_out(dut_out_a), .rec_valid(rec_valid_a), .rec_ready(rec_ready_a),
        .rec_n0(rec_n0_a), .rec_bits(rec_bits_a), .busy(busy_a), .done(done_a)
    );

    // Instance B: ten samples so stim_n wraps
    logic       reset_b, start_b, dut_rst_b, rec_valid_b, rec_ready_b, busy_b, done_b;
    logic [2:0] stim_b, rec_n0_b;
    logic [9:0] rec_bits_b;

    bench_capture_sequencer #(.NUM_SAMPLES(10)) u_b (
        .CK(CK), .reset(reset_b), .start(start_b), .dut_rst(dut_rst_b), .stim_n(stim_b),
        .dut_out(stim_b[0]), .rec_valid(rec_valid_b), .rec_ready(rec_ready_b),
        .rec_n0(rec_n0_b), .rec_bits(rec_bits_b), .busy(busy_b), .done(done_b)
    );

    // Instance C: no settle window
    logic       reset_c, start_c, dut_rst_c, rec_valid_c, rec_ready_c, busy_c, done_c;
    logic [2:0] stim_c, rec_n0_c;
    logic [7:0] rec_bits_c;

    bench_capture_sequencer #(.SETTLE_CYCLES(0)) u_c (
        .CK(CK), .reset(reset_c), .start(start_c), .dut_rst(dut_rst_c), .stim_n(stim_c),
        .dut_out(stim_c[1]), .rec_valid(rec_valid_c), .rec_ready(rec_ready_c),
        .rec_n0(rec_n0_c), .rec_bits(rec_bits_c), .busy(busy_c), .done(done_c)
    );

    always @(negedge CK) begin
        if (rec_valid_a && rec_ready_a) begin
            if (q_a.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rec_a_unexpected: got bits %0h expected no record", rec_bits_a);
            end else begin
                e_a = q_a.pop_front();
                chk("rec_a_n0", 64'(rec_n0_a), e_a.n0);
                chk("rec_a_bits", 64'(rec_bits_a), e_a.bits);
            end
        end
    end

    always @(negedge CK) begin
        if (rec_valid_b && rec_ready_b) begin
            if (q_b.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rec_b_unexpected: got bits %0h expected no record", rec_bits_b);
            end else begin
                e_b = q_b.pop_front();
                chk("rec_b_n0", 64'(rec_n0_b), e_b.n0);
                chk("rec_b_bits", 64'(rec_bits_b), e_b.bits);
            end
        end
    end

    always @(negedge CK) begin
        if (rec_valid_c && rec_ready_c) begin
            if (q_c.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rec_c_unexpected: got bits %0h expected no record", rec_bits_c);
            end else begin
                e_c = q_c.pop_front();
                chk("rec_c_n0", 64'(rec_n0_c), e_c.n0);
                chk("rec_c_bits", 64'(rec_bits_c), e_c.bits);
            end
        end
    end

    task automatic pulse_a();
        @(posedge CK); #1 start_a = 1'b1;
        @(posedge CK); #1 start_a = 1'b0;
    endtask

    task automatic wait_valid_a();
        int n = 0;
        while (!rec_valid_a && n < 40) begin
            @(negedge CK);
            n++;
        end
        chk("wait_valid_a", 64'(rec_valid_a), 64'd1);
    endtask

    // Expected per-cycle view of instance A, index k = cycles after the accepting edge
    logic [12:0] t1_rst   = 13'b0_0000_0000_0011;
    logic [12:0] t1_valid = 13'b0_1000_0000_0000;
    logic [12:0] t1_done  = 13'b1_0000_0000_0000;
    logic [12:0] t1_busy  = 13'b0_1111_1111_1111;
    int          t1_stim [13] = '{0, 0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 0, 0};
    int          t4_stim [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_a = 1; reset_b = 1; reset_c = 1;
        start_a = 0; start_b = 0; start_c = 0;
        rec_ready_a = 1; rec_ready_b = 1; rec_ready_c = 1;
        mode_a = 0;
        repeat (2) @(posedge CK);
        @(negedge CK);
        chk("rst_dut_rst", 64'(dut_rst_a), 64'd1);
        chk("rst_stim",    64'(stim_a), 64'd0);
        chk("rst_valid",   64'(rec_valid_a), 64'd0);
        chk("rst_n0",      64'(rec_n0_a), 64'd0);
        chk("rst_bits",    64'(rec_bits_a), 64'd0);
        chk("rst_busy",    64'(busy_a), 64'd0);
        chk("rst_done",    64'(done_a), 64'd0);

        // 1: dut_out tied high; start also pulsed during SETTLE (k=2) and must be ignored
        @(posedge CK); #1;
        reset_a = 0; reset_b = 0; reset_c = 0;
        start_a = 1;
        q_a.push_back('{64'd0, 64'hFF});
        @(posedge CK); #1 start_a = 0;
        for (int k = 0; k < 13; k++) begin
            @(negedge CK);
            chk($sformatf("t1_rst_k%0d", k),   64'(dut_rst_a),   64'(t1_rst[k]));
            chk($sformatf("t1_valid_k%0d", k), 64'(rec_valid_a), 64'(t1_valid[k]));
            chk($sformatf("t1_done_k%0d", k),  64'(done_a),      64'(t1_done[k]));
            chk($sformatf("t1_busy_k%0d", k),  64'(busy_a),      64'(t1_busy[k]));
            chk($sformatf("t1_stim_k%0d", k),  64'(stim_a),      64'(t1_stim[k]));
            if (k == 1) begin @(posedge CK); #1 start_a = 1; end
            if (k == 2) begin @(posedge CK); #1 start_a = 0; end
        end

        // 2: parity DUT, ready held high; restart from DONE
        mode_a = 1;
        q_a.push_back('{64'd0, 64'hAA});
        pulse_a();
        @(negedge CK);
        chk("t2_restart_rst", 64'(dut_rst_a), 64'd1);
        chk("t2_restart_done", 64'(done_a), 64'd0);
        wait_valid_a();
        @(negedge CK);
        chk("t2_valid_1cyc", 64'(rec_valid_a), 64'd0);
        chk("t2_done", 64'(done_a), 64'd1);

        // 3: ready low for 4 valid cycles, start pulsed during EMIT
        mode_a = 2;
        rec_ready_a = 0;
        q_a.push_back('{64'd0, 64'h55});
        pulse_a();
        wait_valid_a();
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge CK);
            chk($sformatf("t3_hold_valid_c%0d", c), 64'(rec_valid_a), 64'd1);
            chk($sformatf("t3_hold_bits_c%0d", c),  64'(rec_bits_a), 64'h55);
            chk($sformatf("t3_hold_done_c%0d", c),  64'(done_a), 64'd0);
            if (c == 0) begin @(posedge CK); #1 start_a = 1; end
            if (c == 1) begin @(posedge CK); #1 start_a = 0; end
        end
        @(posedge CK); #1 rec_ready_a = 1;
        @(negedge CK);
        chk("t3_ready_cyc_valid", 64'(rec_valid_a), 64'd1);
        @(negedge CK);
        chk("t3_done", 64'(done_a), 64'd1);
        chk("t3_valid_drop", 64'(rec_valid_a), 64'd0);
        @(negedge CK);
        chk("t3_done_stays", 64'(done_a), 64'd1);
        chk("t3_no_restart", 64'(dut_rst_a), 64'd0);

        // 5: reset during SAMPLE, at the third sample edge
        mode_a = 0;
        pulse_a();
        repeat (5) @(posedge CK);
        #1 reset_a = 1;
        @(negedge CK);
        chk("t5_pre_stim", 64'(stim_a), 64'd2);
        chk("t5_pre_bits", 64'(rec_bits_a), 64'h03);
        @(posedge CK); #1 reset_a = 0;
        @(negedge CK);
        chk("t5_idle_rst", 64'(dut_rst_a), 64'd1);
        chk("t5_idle_valid", 64'(rec_valid_a), 64'd0);
        chk("t5_idle_bits", 64'(rec_bits_a), 64'd0);
        chk("t5_idle_stim", 64'(stim_a), 64'd0);
        chk("t5_idle_busy", 64'(busy_a), 64'd0);
        q_a.push_back('{64'd0, 64'hFF});
        pulse_a();
        wait_valid_a();
        @(negedge CK);
        chk("t5_clean_done", 64'(done_a), 64'd1);

        // 4: ten samples, stim_n wraps modulo 8
        q_b.push_back('{64'd0, 64'h2AA});
        @(posedge CK); #1 start_b = 1;
        @(posedge CK); #1 start_b = 0;
        repeat (4) @(negedge CK);
        for (int j = 0; j < 10; j++) begin
            chk($sformatf("t4_stim_j%0d", j), 64'(stim_b), 64'(t4_stim[j]));
            @(negedge CK);
        end
        chk("t4_valid", 64'(rec_valid_b), 64'd1);
        @(negedge CK);
        chk("t4_done", 64'(done_b), 64'd1);
        chk("t4_last_stim", 64'(stim_b), 64'd2);

        // 6: no settle window, first sample at t0+RST_CYCLES+1
        q_c.push_back('{64'd0, 64'hCC});
        @(posedge CK); #1 start_c = 1;
        @(posedge CK); #1 start_c = 0;
        @(negedge CK);
        chk("t6_k0_rst", 64'(dut_rst_c), 64'd1);
        @(negedge CK);
        chk("t6_k1_rst", 64'(dut_rst_c), 64'd1);
        @(negedge CK);
        chk("t6_k2_rst", 64'(dut_rst_c), 64'd0);
        chk("t6_k2_stim", 64'(stim_c), 64'd0);
        @(negedge CK);
        chk("t6_k3_stim", 64'(stim_c), 64'd1);
        repeat (7) @(negedge CK);
        chk("t6_valid", 64'(rec_valid_c), 64'd1);
        @(negedge CK);
        chk("t6_done", 64'(done_c), 64'd1);

        repeat (2) @(negedge CK);
        chk("q_a_drained", 64'(q_a.size()), 64'd0);
        chk("q_b_drained", 64'(q_b.size()), 64'd0);
        chk("q_c_drained", 64'(q_c.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
